// File: rtl/ps2_key_decoder.sv
// PS/2 key event decoder.
// Pops raw scan-code bytes from the ps2_keyboard FIFO, folds the E0/F0
// prefixes into complete key events, tracks the shift/ctrl/alt modifiers,
// optionally drops typematic repeats of the held key, counts key presses,
// and queues events in a first-word fall-through FIFO with valid/ready.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH    = 8,
    parameter int CNT_W         = 8,
    parameter int FILTER_REPEAT = 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    input  logic             ps2_overflow,
    output logic             ps2_nextdata_n,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic [2:0]       evt_mods,
    output logic [CNT_W-1:0] press_cnt,
    output logic             held,
    output logic             err_sticky
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    localparam logic [7:0] BYTE_EXT   = 8'hE0;
    localparam logic [7:0] BYTE_BRK   = 8'hF0;
    localparam logic [7:0] KEY_LSHIFT = 8'h12;
    localparam logic [7:0] KEY_RSHIFT = 8'h59;
    localparam logic [7:0] KEY_CTRL   = 8'h14;
    localparam logic [7:0] KEY_ALT    = 8'h11;

    typedef enum logic {
        IDLE,
        GAP
    } state_t;

    typedef struct packed {
        logic [2:0] mods;
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    state_t          state;
    logic            ext_f;
    logic            brk_f;
    logic [2:0]      mods;
    logic [8:0]      last_key;

    evt_t            mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    logic            full;
    logic            capture;
    logic            is_ext_byte;
    logic            is_brk_byte;
    logic            is_key;
    logic [8:0]      key;
    logic            key_match;
    logic            drop;
    logic            push;
    logic            pop;
    logic [2:0]      mods_next;
    evt_t            new_evt;
    evt_t            head;

    // Fetch handshake: a byte is taken only when there is room to store its event.
    always_comb begin
        full           = (count == DEPTH_C);
        capture        = (state == IDLE) && ps2_ready && !full;
        ps2_nextdata_n = !(clrn && capture);
    end

    // Byte classification, modifier update and repeat filtering for the captured byte.
    always_comb begin
        is_ext_byte = (ps2_data == BYTE_EXT);
        is_brk_byte = (ps2_data == BYTE_BRK);
        is_key      = capture && !is_ext_byte && !is_brk_byte;
        key         = {ext_f, ps2_data};
        key_match   = (key == last_key);

        mods_next = mods;
        if (is_key) begin
            case (ps2_data)
                KEY_LSHIFT, KEY_RSHIFT: mods_next[0] = !brk_f;
                KEY_CTRL:               mods_next[1] = !brk_f;
                KEY_ALT:                mods_next[2] = !brk_f;
                default:                mods_next    = mods;
            endcase
        end

        drop = is_key && !brk_f && (FILTER_REPEAT != 0) && held && key_match;
        push = is_key && !drop;

        new_evt.mods = mods_next;
        new_evt.ext  = ext_f;
        new_evt.brk  = brk_f;
        new_evt.code = ps2_data;
    end

    // Fetch FSM: one capture cycle, then one gap cycle so the source head can advance.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= capture ? GAP : IDLE;
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Prefix flags accumulate until a non-prefix byte closes the sequence.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
        end else if (capture) begin
            if (is_ext_byte) begin
                ext_f <= 1'b1;
            end else if (is_brk_byte) begin
                brk_f <= 1'b1;
            end else begin
                ext_f <= 1'b0;
                brk_f <= 1'b0;
            end
        end
    end

    // Modifier state, held-key tracking and press counting.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mods      <= '0;
            last_key  <= '0;
            held      <= 1'b0;
            press_cnt <= '0;
        end else if (is_key) begin
            mods <= mods_next;
            if (!brk_f) begin
                if (!drop) begin
                    last_key  <= key;
                    held      <= 1'b1;
                    press_cnt <= press_cnt + 1'b1;
                end
            end else if (key_match) begin
                held <= 1'b0;
            end
        end
    end

    // Sticky record of any upstream FIFO overflow.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            err_sticky <= 1'b0;
        end else if (ps2_overflow) begin
            err_sticky <= 1'b1;
        end
    end

    // Event storage; contents are don't-care while empty because outputs are gated.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_evt;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Fall-through head; fields read zero whenever the FIFO is empty.
    always_comb begin
        evt_valid = (count != '0);
        pop       = evt_valid && evt_ready;
        head      = mem[rd_ptr];
        evt_code  = evt_valid ? head.code : '0;
        evt_ext   = evt_valid ? head.ext  : 1'b0;
        evt_break = evt_valid ? head.brk  : 1'b0;
        evt_mods  = evt_valid ? head.mods : '0;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Parametrised successor to the single-byte keyboard_read path.
- Pops raw scan-code bytes from ps2_keyboard and parses the E0 (extended) and F0 (break) prefixes into complete key events.
- Tracks the shift, ctrl and alt modifiers, optionally filters typematic repeats, and counts key presses.
- Buffers events in an internal FIFO with a valid/ready output interface, feeding keyboard_display and later consumers.

Parameters:
- FIFO_DEPTH, 8: event FIFO entries; power of two, at least 2.
- CNT_W, 8: width of the press counter.
- FILTER_REPEAT, 1: 1 drops typematic repeat make codes of the currently held key; 0 passes every make.

Ports:
- clk  in  1  system clock; all state on rising edge.
- clrn  in  1  asynchronous active-low reset.
- ps2_data  in  8  head byte of the ps2_keyboard FIFO.
- ps2_ready  in  1  ps2_data is valid.
- ps2_overflow  in  1  ps2_keyboard FIFO overflow.
- ps2_nextdata_n  out  1  active-low, one-cycle pop strobe to ps2_keyboard.
- evt_valid  out  1  event FIFO not empty.
- evt_ready  in  1  consumer accepts the head event.
- evt_code  out  8  scan code, prefixes stripped.
- evt_ext  out  1  event was E0-prefixed.
- evt_break  out  1  event is a release.
- evt_mods  out  3  {alt, ctrl, shift} after this event was applied.
- press_cnt  out  CNT_W  count of accepted make events.
- held  out  1  last accepted make key not yet released.
- err_sticky  out  1  ps2_overflow was seen since reset.

Behaviour:
- Reset (clrn=0, asynchronous):
  - FIFO empty, so evt_valid=0; evt_code, evt_ext, evt_break and evt_mods read 0.
  - press_cnt=0, held=0, err_sticky=0, ps2_nextdata_n=1.
  - Prefix flags, modifiers, last-key register and FSM (state IDLE) all cleared.
  - Reset mid-prefix discards the partial sequence.
- Fetch FSM, two states, IDLE and GAP:
  - In IDLE, when ps2_ready=1 and the FIFO is not full: ps2_nextdata_n=0 for that single cycle, ps2_data is decoded, and the FSM enters GAP.
  - GAP lasts one cycle so ps2_ready can update, then returns to IDLE.
  - ps2_nextdata_n is combinational from state and registers: low only in IDLE with ps2_ready=1 and not full.
  - When the FIFO is full no byte is popped. The block applies lossless backpressure.
- Decode, on the capture edge:
  - Byte E0: set ext_f. No event.
  - Byte F0: set brk_f. No event.
  - Any other byte: form the event {ext_f, brk_f, byte}, then clear ext_f and brk_f.
  - Modifier update: 12 or 59 sets shift on make and clears it on break; 14 (with or without ext) does the same for ctrl; 11 does the same for alt.
  - evt_mods stores the modifiers after the update.
- Make event handling:
  - FILTER_REPEAT=1 with held=1 and {ext, code} equal to last_key: the event is dropped. No push, no count change.
  - Otherwise the event is pushed, last_key<={ext, code}, held<=1, and press_cnt increments, wrapping modulo 2^CNT_W.
- Break event handling:
  - The event is always pushed.
  - If {ext, code} equals last_key, then held<=0.
  - press_cnt is unchanged.
- Latency: the decoded event is written on the capture edge, so evt_valid=1 in the next cycle when the FIFO was empty.
- Event FIFO:
  - First-word fall-through; evt_* outputs show the head entry.
  - Pop on evt_valid && evt_ready.
  - Simultaneous push and pop: occupancy unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - Occupancy counter is log2(FIFO_DEPTH)+1 bits.
  - Full means occupancy equals FIFO_DEPTH.
- err_sticky: set on any cycle with ps2_overflow=1; cleared only by reset.
- Maximum throughput: one byte per 2 cycles.

Test Plan:
1. Bytes 1C then F0 1C, evt_ready=1:
   - First event: code=1C, ext=0, brk=0; press_cnt=1, held=1.
   - Second event: code=1C, brk=1; held=0, press_cnt=1.
   - ps2_nextdata_n is low exactly one cycle per byte.
2. E0 75 then E0 F0 75 → two events, both code=75, ext=1, with brk=0 then brk=1. No events are emitted for the prefix bytes.
3. Bytes 1C 1C 1C F0 1C:
   - FILTER_REPEAT=1: 2 events, press_cnt=1.
   - FILTER_REPEAT=0: 4 events, press_cnt=3.
4. FIFO_DEPTH=8, evt_ready=0, makes 15,1D,24,2D,2C,35,3C,43,44 (9 keys):
   - The FIFO fills after 8 events; ps2_nextdata_n stays 1 and byte 44 stays pending.
   - Setting evt_ready=1 drains all 9 events in order, with no loss.
5. Modifiers: 12, 1C, F0 12, 1C → evt_mods=001 on the first 1C and 000 on the last 1C. E0 14 → ctrl set, evt_mods=010.
6. Reset and error cases:
   - clrn pulsed low after E0, then 74 → event with ext=0.
   - ps2_overflow high for 1 cycle → err_sticky=1 until reset.
   - 256 distinct-key make/break pairs with CNT_W=8 → press_cnt wraps to 0.
